// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one fixed-latency single-ported memory between IF and DM requesters.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed DM priority.
module mem_port_arbiter #(
  parameter int unsigned datasize = 32,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [datasize-1:0] if_addr,
  output logic [datasize-1:0] if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [datasize-1:0] dm_addr,
  input  logic [datasize-1:0] dm_wdata,
  output logic [datasize-1:0] dm_rdata,
  output logic                dm_ready,
  output logic                stall_if,
  output logic                stall_dm,
  output logic                mem_en,
  output logic                mem_we,
  output logic [datasize-1:0] mem_addr,
  output logic [datasize-1:0] mem_wdata,
  input  logic [datasize-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  state_e              state_q, state_d;
  logic                owner_dm_q, owner_dm_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [datasize-1:0] mem_addr_q, mem_addr_d;
  logic [datasize-1:0] mem_wdata_q, mem_wdata_d;
  logic [datasize-1:0] if_rdata_q, if_rdata_d;
  logic [datasize-1:0] dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;

  logic if_elig, dm_elig, grant_dm;

  assign if_elig = if_req & ~if_ready_q;
  assign dm_elig = dm_req & ~dm_ready_q;

`ifdef MEM_ARB_RR_EN
  // Remembers the winner of the last contested grant (1 = DM); resets to IF so DM wins first.
  logic last_dm_q, last_dm_d;

  always_comb begin
    last_dm_d = last_dm_q;
    grant_dm  = dm_elig;
    if (dm_elig && if_elig) begin
      grant_dm = ~last_dm_q;
      if (state_q == StIdle) begin
        last_dm_d = ~last_dm_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dm_q <= 1'b0;
    end else begin
      last_dm_q <= last_dm_d;
    end
  end
`else
  assign grant_dm = dm_elig;
`endif

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = if_ready_q;
    dm_ready_d  = dm_ready_q;

    case (state_q)
      StIdle: begin
        if (dm_elig || if_elig) begin
          state_d    = StIssue;
          owner_dm_d = grant_dm;
          mem_en_d   = 1'b1;
          if (grant_dm) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      StIssue: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        cnt_d    = LatInit;
        state_d  = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        // Count of 1 marks the last latency cycle: mem_rdata is valid now.
        if (cnt_q == 3'd1) begin
          state_d = StDone;
          if (owner_dm_q) begin
            dm_rdata_d = mem_rdata;
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end
        end
      end
      StDone: begin
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_dm_q  <= 1'b0;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_dm  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 7) share stimulus,
// each with its own fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam logic [31:0] Junk = 32'hBAD0BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, stall_if, stall_dm, mem_en, mem_we;

  logic [31:0] if_rdata_l1, dm_rdata_l1, mem_addr_l1, mem_wdata_l1, mem_rdata_l1;
  logic        if_ready_l1, dm_ready_l1, stall_if_l1, stall_dm_l1, mem_en_l1, mem_we_l1;

  logic [31:0] if_rdata_l7, dm_rdata_l7, mem_addr_l7, mem_wdata_l7, mem_rdata_l7;
  logic        if_ready_l7, dm_ready_l7, stall_if_l7, stall_dm_l7, mem_en_l7, mem_we_l7;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.datasize(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.datasize(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_l1), .if_ready(if_ready_l1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata_l1), .dm_ready(dm_ready_l1), .stall_if(stall_if_l1),
    .stall_dm(stall_dm_l1), .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1),
    .mem_wdata(mem_wdata_l1), .mem_rdata(mem_rdata_l1)
  );

  mem_port_arbiter #(.datasize(32), .MEM_LAT(7)) u_dut_l7 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_l7), .if_ready(if_ready_l7),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata_l7), .dm_ready(dm_ready_l7), .stall_if(stall_if_l7),
    .stall_dm(stall_dm_l7), .mem_en(mem_en_l7), .mem_we(mem_we_l7), .mem_addr(mem_addr_l7),
    .mem_wdata(mem_wdata_l7), .mem_rdata(mem_rdata_l7)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C010004 : (a ^ 32'h5A5A0000);
  endfunction

  // Memory models: data is valid exactly MEM_LAT cycles after the mem_en cycle, junk otherwise.
  logic [31:0] pipe2 [2];
  logic [31:0] pipe1;
  logic [31:0] pipe7 [7];

  always @(posedge clk) begin
    pipe2[1] <= pipe2[0];
    pipe2[0] <= (mem_en && !mem_we) ? mem_val(mem_addr) : Junk;
    pipe1    <= (mem_en_l1 && !mem_we_l1) ? mem_val(mem_addr_l1) : Junk;
    for (int k = 6; k > 0; k--) pipe7[k] <= pipe7[k-1];
    pipe7[0] <= (mem_en_l7 && !mem_we_l7) ? mem_val(mem_addr_l7) : Junk;
  end

  assign mem_rdata    = pipe2[1];
  assign mem_rdata_l1 = pipe1;
  assign mem_rdata_l7 = pipe7[6];

  task automatic do_reset();
    reset  = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en c=%0d got %b want 0", c, mem_en); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we c=%0d got %b want 0", c, mem_we); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr c=%0d got %h want 0", c, mem_addr); end
      n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata c=%0d got %h want 0", c, mem_wdata); end
      n_cmp++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata c=%0d got %h want 0", c, if_rdata); end
      n_cmp++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_rdata c=%0d got %h want 0", c, dm_rdata); end
      n_cmp++; if ({if_ready, dm_ready, stall_if, stall_dm} !== 4'b0) begin
        n_fail++; $display("FAIL reset_flags c=%0d got %b want 0000", c, {if_ready, dm_ready, stall_if, stall_dm});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_if_read();
    if_addr = 32'h40;
    for (int c = 0; c < 6; c++) begin
      if_req = (c <= 4);
      @(negedge clk);
      n_cmp++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL if_mem_en c=%0d got %b want %b", c, mem_en, c == 1); end
      n_cmp++; if (if_ready !== (c == 4)) begin n_fail++; $display("FAIL if_ready c=%0d got %b want %b", c, if_ready, c == 4); end
      n_cmp++; if (stall_if !== (c <= 3)) begin n_fail++; $display("FAIL if_stall c=%0d got %b want %b", c, stall_if, c <= 3); end
      n_cmp++; if (dm_ready !== 1'b0) begin n_fail++; $display("FAIL if_dm_ready c=%0d got %b want 0", c, dm_ready); end
      if (c == 1) begin
        n_cmp++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL if_mem_addr got %h want 00000040", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL if_mem_we got %b want 0", mem_we); end
      end
      if (c == 4) begin
        n_cmp++; if (if_rdata !== 32'h8C010004) begin n_fail++; $display("FAIL if_rdata got %h want 8c010004", if_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dm_write();
    dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      dm_req = (c <= 4);
      @(negedge clk);
      n_cmp++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL wr_mem_en c=%0d got %b want %b", c, mem_en, c == 1); end
      n_cmp++; if (dm_ready !== (c == 4)) begin n_fail++; $display("FAIL wr_dm_ready c=%0d got %b want %b", c, dm_ready, c == 4); end
      n_cmp++; if (stall_dm !== (c <= 3)) begin n_fail++; $display("FAIL wr_stall c=%0d got %b want %b", c, stall_dm, c <= 3); end
      n_cmp++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL wr_if_ready c=%0d got %b want 0", c, if_ready); end
      if (c == 1) begin
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL wr_mem_addr got %h want 00000100", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_wdata got %h want deadbeef", mem_wdata); end
      end
      @(posedge clk); #1;
    end
    dm_we = 1'b0;
  endtask

  task automatic test_dm_read();
    dm_we = 1'b0; dm_addr = 32'h200;
    for (int c = 0; c < 6; c++) begin
      dm_req = (c <= 4);
      @(negedge clk);
      n_cmp++; if (mem_en !== (c == 1)) begin n_fail++; $display("FAIL rd_mem_en c=%0d got %b want %b", c, mem_en, c == 1); end
      n_cmp++; if (dm_ready !== (c == 4)) begin n_fail++; $display("FAIL rd_dm_ready c=%0d got %b want %b", c, dm_ready, c == 4); end
      if (c == 1) begin
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we got %b want 0", mem_we); end
      end
      if (c == 4) begin
        n_cmp++; if (dm_rdata !== 32'h5A5A0200) begin n_fail++; $display("FAIL rd_dm_rdata got %h want 5a5a0200", dm_rdata); end
        n_cmp++; if (if_rdata !== 32'h8C010004) begin n_fail++; $display("FAIL rd_if_rdata_hold got %h want 8c010004", if_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  // Both requests rise together; first-served completes at cycle 4, the other at cycle 9.
  task automatic test_simultaneous(input bit dm_first);
    logic [31:0] a1, a6;
    int dm_rdy_c, if_rdy_c;
    dm_we = 1'b0; dm_addr = 32'h300; if_addr = 32'h44;
    a1 = dm_first ? 32'h300 : 32'h44;
    a6 = dm_first ? 32'h44 : 32'h300;
    dm_rdy_c = dm_first ? 4 : 9;
    if_rdy_c = dm_first ? 9 : 4;
    for (int c = 0; c < 12; c++) begin
      dm_req = (c <= dm_rdy_c);
      if_req = (c <= if_rdy_c);
      @(negedge clk);
      n_cmp++; if (mem_en !== (c == 1 || c == 6)) begin n_fail++; $display("FAIL tie_mem_en c=%0d got %b want %b", c, mem_en, c == 1 || c == 6); end
      n_cmp++; if (dm_ready !== (c == dm_rdy_c)) begin n_fail++; $display("FAIL tie_dm_ready c=%0d got %b want %b", c, dm_ready, c == dm_rdy_c); end
      n_cmp++; if (if_ready !== (c == if_rdy_c)) begin n_fail++; $display("FAIL tie_if_ready c=%0d got %b want %b", c, if_ready, c == if_rdy_c); end
      n_cmp++; if (stall_dm !== (c < dm_rdy_c)) begin n_fail++; $display("FAIL tie_stall_dm c=%0d got %b want %b", c, stall_dm, c < dm_rdy_c); end
      n_cmp++; if (stall_if !== (c < if_rdy_c)) begin n_fail++; $display("FAIL tie_stall_if c=%0d got %b want %b", c, stall_if, c < if_rdy_c); end
      n_cmp++; if ((if_ready & dm_ready) !== 1'b0) begin n_fail++; $display("FAIL tie_both_ready c=%0d got 1 want 0", c); end
      if (c == 1) begin
        n_cmp++; if (mem_addr !== a1) begin n_fail++; $display("FAIL tie_addr_first got %h want %h", mem_addr, a1); end
      end
      if (c == 6) begin
        n_cmp++; if (mem_addr !== a6) begin n_fail++; $display("FAIL tie_addr_second got %h want %h", mem_addr, a6); end
      end
      if (c == dm_rdy_c) begin
        n_cmp++; if (dm_rdata !== 32'h5A5A0300) begin n_fail++; $display("FAIL tie_dm_rdata got %h want 5a5a0300", dm_rdata); end
      end
      if (c == if_rdy_c) begin
        n_cmp++; if (if_rdata !== 32'h5A5A0044) begin n_fail++; $display("FAIL tie_if_rdata got %h want 5a5a0044", if_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    if_addr = 32'h80;
    for (int c = 0; c < 10; c++) begin
      if_req = (c <= 7);
      reset  = (c == 2);
      @(negedge clk);
      n_cmp++; if (mem_en !== (c == 1 || c == 4)) begin n_fail++; $display("FAIL rst_mem_en c=%0d got %b want %b", c, mem_en, c == 1 || c == 4); end
      n_cmp++; if (if_ready !== (c == 7)) begin n_fail++; $display("FAIL rst_if_ready c=%0d got %b want %b", c, if_ready, c == 7); end
      n_cmp++; if (stall_if !== (c <= 6)) begin n_fail++; $display("FAIL rst_stall c=%0d got %b want %b", c, stall_if, c <= 6); end
      if (c == 3) begin
        n_cmp++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata_clr got %h want 0", if_rdata); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr_clr got %h want 0", mem_addr); end
      end
      if (c == 7) begin
        n_cmp++; if (if_rdata !== 32'h5A5A0080) begin n_fail++; $display("FAIL rst_if_rdata got %h want 5a5a0080", if_rdata); end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  // One-cycle request pulse: grant happens on the pulse, the access completes anyway.
  task automatic test_latency();
    do_reset();
    dm_we = 1'b0; dm_addr = 32'h140;
    for (int c = 0; c < 12; c++) begin
      dm_req = (c == 0);
      @(negedge clk);
      n_cmp++; if (mem_en_l1 !== (c == 1)) begin n_fail++; $display("FAIL lat1_mem_en c=%0d got %b want %b", c, mem_en_l1, c == 1); end
      n_cmp++; if (mem_en_l7 !== (c == 1)) begin n_fail++; $display("FAIL lat7_mem_en c=%0d got %b want %b", c, mem_en_l7, c == 1); end
      n_cmp++; if (dm_ready_l1 !== (c == 3)) begin n_fail++; $display("FAIL lat1_ready c=%0d got %b want %b", c, dm_ready_l1, c == 3); end
      n_cmp++; if (dm_ready_l7 !== (c == 9)) begin n_fail++; $display("FAIL lat7_ready c=%0d got %b want %b", c, dm_ready_l7, c == 9); end
      n_cmp++; if (dm_ready !== (c == 4)) begin n_fail++; $display("FAIL lat2_ready c=%0d got %b want %b", c, dm_ready, c == 4); end
      if (c == 3) begin
        n_cmp++; if (dm_rdata_l1 !== 32'h5A5A0140) begin n_fail++; $display("FAIL lat1_rdata got %h want 5a5a0140", dm_rdata_l1); end
      end
      if (c == 4) begin
        n_cmp++; if (dm_rdata !== 32'h5A5A0140) begin n_fail++; $display("FAIL lat2_rdata got %h want 5a5a0140", dm_rdata); end
      end
      if (c == 9) begin
        n_cmp++; if (dm_rdata_l7 !== 32'h5A5A0140) begin n_fail++; $display("FAIL lat7_rdata got %h want 5a5a0140", dm_rdata_l7); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit second_dm_first;
`ifdef MEM_ARB_RR_EN
    second_dm_first = 1'b0;
`else
    second_dm_first = 1'b1;
`endif
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_if_read();
    test_dm_write();
    test_dm_read();
    do_reset();
    test_simultaneous(1'b1);
    test_simultaneous(second_dm_first);
    test_reset_mid();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between two requesters in the MIPS pipeline: instruction fetch (IF) and data memory (DM, MEM stage).
- Serialises accesses, returns read data to the granted requester and raises per-requester stall so the hazard logic can freeze the pipeline.
- Sits between the datapath's fetch/memory-stage address buses and the external memory macro.

Parameters:
- datasize, 32, data and address width in bits.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch read request; held until if_ready.
- if_addr  input  datasize  fetch byte address.
- if_rdata  output  datasize  fetched instruction, valid while if_ready=1.
- if_ready  output  1  one-cycle completion pulse for fetch.
- dm_req  input  1  data request; held until dm_ready.
- dm_we  input  1  1=write, 0=read.
- dm_addr  input  datasize  data byte address.
- dm_wdata  input  datasize  store data.
- dm_rdata  output  datasize  load data, valid while dm_ready=1.
- dm_ready  output  1  one-cycle completion pulse for data.
- stall_if  output  1  if_req & ~if_ready (combinational).
- stall_dm  output  1  dm_req & ~dm_ready (combinational).
- mem_en  output  1  memory access strobe, one cycle per access.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  datasize  memory address.
- mem_wdata  output  datasize  memory write data.
- mem_rdata  input  datasize  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- All outputs except stall_if/stall_dm are registered.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0; state=IDLE; counter=0.
- FSM states: IDLE, ISSUE, WAIT, DONE. Grant owner register: IF or DM.
- IDLE:
  - A requester is eligible if its req=1 and its ready=0 this cycle. This prevents re-issuing a just-completed request.
  - If DM is eligible, grant DM (fixed priority). Otherwise, if IF is eligible, grant IF.
  - On grant, latch the address; for DM, also latch we and wdata. Go to ISSUE.
- ISSUE (cycle E):
  - mem_en=1; mem_we=latched we (always 0 for IF); mem_addr and mem_wdata driven from latched values.
  - Load counter with MEM_LAT; go to WAIT.
- WAIT:
  - mem_en=0; counter decrements each cycle.
  - At the edge ending cycle E+MEM_LAT, capture mem_rdata into the owner's rdata register (DM writes also capture; value is don't-care) and go to DONE.
- DONE (cycle E+MEM_LAT+1):
  - Owner's ready=1 for exactly this cycle; rdata holds its value until the next capture.
  - Go to IDLE. The arbitration in that IDLE cycle uses the eligibility rule above.
- Timing:
  - Per-access latency, req-seen to ready, is MEM_LAT+2 cycles; stall is asserted for MEM_LAT+2 cycles.
  - Minimum spacing between mem_en pulses is MEM_LAT+3 cycles.
- Simultaneous requests: DM is served first; IF waits in stall for the full DM access and is then served.
- A request dropped while it is not granted is ignored. A request dropped after grant still completes; its ready pulse is produced and ignored by the pipeline.
- Reset mid-access: FSM returns to IDLE, ready outputs clear, and the in-flight memory response is discarded. No mem_en is issued in the cycle after reset.
- Only one access is outstanding at a time; if_ready and dm_ready are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are eligible in IDLE, grant the one not granted last. The last-grant register resets to IF, so DM wins the first tie.
- Undefined: fixed DM-over-IF priority as described in Behaviour.

Test Plan (MEM_LAT=2 unless noted):
- Reset held, then released with no requests -> all outputs 0; mem_en stays 0.
- if_req=1, if_addr=0x00000040 at cycle 0 -> mem_en=1 with addr 0x40 at cycle 1; memory returns 0x8C010004 at cycle 3 -> if_ready=1 and if_rdata=0x8C010004 at cycle 4; stall_if high cycles 0-3.
- dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; dm_ready at cycle 4; if_ready stays 0.
- if_req and dm_req both rise at cycle 0 -> DM mem_en at cycle 1, dm_ready at cycle 4; IF mem_en at cycle 6, if_ready at cycle 9. With MEM_ARB_RR_EN, a second tie after both complete is granted to IF first.
- Reset asserted at cycle 2 of an IF access -> no if_ready pulse; next request starts clean with latency 4.
- MEM_LAT=1 and MEM_LAT=7 -> DM read ready at cycles 3 and 9 respectively, with rdata equal to the memory model's value.
